mdu: RTL and testbench

Multi-cycle multiply/divide unit in the EX stage of the 5-stage MIPS pipeline. It executes mult/multu/div/divu and mthi/mtlo, owns the HI/LO registers, and drives the `busy` signal that the hazard unit uses to stall mfhi/mflo/mthi/mtlo and further mult/div in ID. Results appear in HI/LO a fixed number of cycles after issue. HI/LO are readable at all times and return the last committed values.

---
 rtl/mdu_pkg.sv | 30 +++
 rtl/mdu_if.sv | 23 ++
 rtl/mdu_calc.sv | 46 ++++
 rtl/mdu.sv | 94 +++++++++
 tb/tb_mdu.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - op codes, state encoding and default latencies for the multiply/divide unit
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6
  } mdu_op_e;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_RUN  = 1'b1
  } mdu_state_e;

  localparam int MDU_MULT_CYCLES = 5;
  localparam int MDU_DIV_CYCLES  = 10;

  function automatic logic is_muldiv(mdu_op_e op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic is_div(mdu_op_e op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_if.sv
// rtl/mdu_if.sv - EX-stage issue port and HI/LO/busy return path of the multiply/divide unit
interface mdu_if;
  import mdu_pkg::*;

  logic        start;
  mdu_op_e     op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, rs_data, rt_data,
    input  busy, hi, lo
  );

  modport slave (
    input  start, op, rs_data, rt_data,
    output busy, hi, lo
  );

endinterface

// File: rtl/mdu_calc.sv
// rtl/mdu_calc.sv - combinational {hi, lo} result for mult/multu/div/divu
module mdu_calc
  import mdu_pkg::*;
(
  input  mdu_op_e     i_op,
  input  logic [31:0] i_rs,
  input  logic [31:0] i_rt,
  output logic [63:0] o_result
);

  logic signed [63:0] w_sa;
  logic signed [63:0] w_sb;
  logic               w_div_zero;
  logic               w_div_ovf;

  assign w_sa       = {{32{i_rs[31]}}, i_rs};
  assign w_sb       = {{32{i_rt[31]}}, i_rt};
  assign w_div_zero = (i_rt == 32'd0);
  assign w_div_ovf  = (i_rs == 32'h8000_0000) && (i_rt == 32'hFFFF_FFFF);

  // Division results are packed as {remainder, quotient} to match HI/LO.
  always_comb begin
    o_result = 64'd0;
    case (i_op)
      MDU_MULT:  o_result = w_sa * w_sb;
      MDU_MULTU: o_result = {32'd0, i_rs} * {32'd0, i_rt};
      MDU_DIV: begin
        if (w_div_zero)
          o_result = {i_rs, 32'hFFFF_FFFF};
        else if (w_div_ovf)
          o_result = {32'd0, 32'h8000_0000};
        else
          o_result = {32'($signed(i_rs) % $signed(i_rt)),
                      32'($signed(i_rs) / $signed(i_rt))};
      end
      MDU_DIVU: begin
        if (w_div_zero)
          o_result = {i_rs, 32'hFFFF_FFFF};
        else
          o_result = {i_rs % i_rt, i_rs / i_rt};
      end
      default:   o_result = 64'd0;
    endcase
  end

endmodule

// File: rtl/mdu.sv
// rtl/mdu.sv - multi-cycle multiply/divide unit owning HI/LO and the ID-stall busy flag
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic i_clk,
  input  logic i_reset,
  mdu_if.slave bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  mdu_state_e       r_state;
  mdu_state_e       w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_p_hi;
  logic [31:0]      r_p_lo;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic [63:0]      w_result;
  logic             w_idle_start;
  logic             w_issue;
  logic             w_commit;
  logic             w_busy;

  mdu_calc u_calc (
    .i_op     (bus.op),
    .i_rs     (bus.rs_data),
    .i_rt     (bus.rt_data),
    .o_result (w_result)
  );

  // Any start seen while RUN is dropped; the hazard unit prevents it.
  assign w_idle_start = (r_state == MDU_IDLE) && bus.start;
  assign w_issue      = w_idle_start && is_muldiv(bus.op);
  assign w_commit     = (r_state == MDU_RUN) && (r_cnt == CNT_W'(1));

  always_ff @(posedge i_clk) begin
    if (!i_reset)
      r_state <= MDU_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      MDU_IDLE: if (w_issue) w_next = MDU_RUN;
      MDU_RUN:  if (w_commit) w_next = MDU_IDLE;
      default:  w_next = MDU_IDLE;
    endcase
  end

  // Busy is combinational on start so the issue cycle already stalls ID.
  always_comb begin
    w_busy = (bus.start && is_muldiv(bus.op)) || (r_state == MDU_RUN);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_cnt  <= '0;
      r_p_hi <= 32'd0;
      r_p_lo <= 32'd0;
      r_hi   <= 32'd0;
      r_lo   <= 32'd0;
    end else begin
      if (w_issue) begin
        r_p_hi <= w_result[63:32];
        r_p_lo <= w_result[31:0];
        r_cnt  <= is_div(bus.op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      end else if (r_state == MDU_RUN) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end

      if (w_commit)
        r_hi <= r_p_hi;
      else if (w_idle_start && (bus.op == MDU_MTHI))
        r_hi <= bus.rs_data;

      if (w_commit)
        r_lo <= r_p_lo;
      else if (w_idle_start && (bus.op == MDU_MTLO))
        r_lo <= bus.rs_data;
    end
  end

  assign bus.busy = w_busy;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule

// File: tb/tb_mdu.sv
// tb/tb_mdu.sv - directed self-checking bench for mdu
module tb_mdu;
  import mdu_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [31:0] cur_hi;
  logic [31:0] cur_lo;

  mdu_if bus ();

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues op in the current cycle T and checks busy/HI/LO through T+n+1.
  task automatic run_op(input string tag, input mdu_op_e op, input logic [31:0] rs,
                        input logic [31:0] rt, input int n,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    bus.start   = 1'b1;
    bus.op      = op;
    bus.rs_data = rs;
    bus.rt_data = rt;
    #1;
    check({tag, " busy T"}, {31'd0, bus.busy}, 32'd1);
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = MDU_NONE;
    for (int k = 1; k <= n; k++) begin
      #1;
      check($sformatf("%s busy T+%0d", tag, k), {31'd0, bus.busy}, 32'd1);
      check($sformatf("%s hi T+%0d", tag, k), bus.hi, cur_hi);
      check($sformatf("%s lo T+%0d", tag, k), bus.lo, cur_lo);
      @(negedge clk);
    end
    #1;
    check({tag, " hi done"}, bus.hi, exp_hi);
    check({tag, " lo done"}, bus.lo, exp_lo);
    check({tag, " busy done"}, {31'd0, bus.busy}, 32'd0);
    cur_hi = exp_hi;
    cur_lo = exp_lo;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b0;
    bus.start   = 1'b0;
    bus.op      = MDU_NONE;
    bus.rs_data = 32'd0;
    bus.rt_data = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("reset hi", bus.hi, 32'd0);
    check("reset lo", bus.lo, 32'd0);
    check("reset busy", {31'd0, bus.busy}, 32'd0);
    cur_hi = 32'd0;
    cur_lo = 32'd0;

    run_op("mult -2x3", MDU_MULT, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu", MDU_MULTU, 32'hFFFF_FFFE, 32'd3, 5, 32'h0000_0002, 32'hFFFF_FFFA);
    run_op("div -7/2", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu 7/0", MDU_DIVU, 32'd7, 32'd0, 10, 32'h0000_0007, 32'hFFFF_FFFF);
    run_op("div ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);
    run_op("divu 100/7", MDU_DIVU, 32'd100, 32'd7, 10, 32'd2, 32'd14);

    bus.start   = 1'b1;
    bus.op      = MDU_MTHI;
    bus.rs_data = 32'h1234_5678;
    #1;
    check("mthi busy T", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = MDU_NONE;
    #1;
    check("mthi hi T+1", bus.hi, 32'h1234_5678);
    check("mthi lo T+1", bus.lo, 32'd14);
    check("mthi busy T+1", {31'd0, bus.busy}, 32'd0);
    cur_hi = 32'h1234_5678;

    // MTLO raised while a MULTU is running must not touch LO.
    bus.start   = 1'b1;
    bus.op      = MDU_MULTU;
    bus.rs_data = 32'd5;
    bus.rt_data = 32'd6;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = MDU_NONE;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.op      = MDU_MTLO;
    bus.rs_data = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = MDU_NONE;
    #1;
    check("mtlo in run lo", bus.lo, 32'd14);
    check("mtlo in run busy", {31'd0, bus.busy}, 32'd1);
    repeat (3) @(negedge clk);
    #1;
    check("multu 5x6 hi", bus.hi, 32'd0);
    check("multu 5x6 lo", bus.lo, 32'd30);
    check("multu 5x6 busy", {31'd0, bus.busy}, 32'd0);

    // Reset asserted in T+4 of a DIV aborts it.
    bus.start   = 1'b1;
    bus.op      = MDU_DIV;
    bus.rs_data = 32'd100;
    bus.rt_data = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = MDU_NONE;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort busy", {31'd0, bus.busy}, 32'd0);
    check("abort hi", bus.hi, 32'd0);
    check("abort lo", bus.lo, 32'd0);
    cur_hi = 32'd0;
    cur_lo = 32'd0;
    @(negedge clk);
    run_op("mult 3x4", MDU_MULT, 32'd3, 32'd4, 5, 32'd0, 32'd12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
